// File: rtl/dlsc_stereobm_outbuf.sv
// dlsc_stereobm_outbuf: output buffer downstream of the stereo block-matching backend.
// Two FIFOs hold the disparity results ({disp,masked,filtered}) and the matching
// left/right pixels. Each FIFO has its own write pointer and occupancy count.
// Both FIFOs share one read pointer because they are always popped together.
// The output is first-word-fall-through: the heads are presented as soon as both
// FIFOs are non-empty. busy is an almost-full throttle for the frontend.
// overflow is a sticky flag for a push that was dropped because its FIFO was full.
// Optional macro DLSC_STEREOBM_OUTBUF_SUBST_EN: lanes flagged masked or filtered
// output INVALID_DISP on out_disp. The substitution happens on the read side.
module dlsc_stereobm_outbuf #(
    parameter int DISP_BITS    = 6,
    parameter int MULT_R       = 3,
    parameter int DATA         = 9,
    parameter int DEPTH        = 96,
    parameter int ALMOST_FULL  = DEPTH - 8,
    parameter int INVALID_DISP = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_disp_valid,
    input  logic [DISP_BITS*MULT_R-1:0] in_disp_data,
    input  logic [MULT_R-1:0]         in_disp_masked,
    input  logic [MULT_R-1:0]         in_disp_filtered,
    input  logic                      in_img_valid,
    input  logic [DATA*MULT_R-1:0]    in_img_left,
    input  logic [DATA*MULT_R-1:0]    in_img_right,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DISP_BITS*MULT_R-1:0] out_disp,
    output logic [MULT_R-1:0]         out_masked,
    output logic [MULT_R-1:0]         out_filtered,
    output logic [DATA*MULT_R-1:0]    out_left,
    output logic [DATA*MULT_R-1:0]    out_right,
    output logic                      busy,
    output logic                      overflow
);

    localparam int DLW = DISP_BITS*MULT_R;
    localparam int DW  = DLW + 2*MULT_R;
    localparam int ILW = DATA*MULT_R;
    localparam int IW  = 2*ILW;
    localparam int CW  = $clog2(DEPTH+1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);
    localparam logic [DISP_BITS-1:0] INVALID_V = DISP_BITS'(INVALID_DISP);

`ifdef DLSC_STEREOBM_OUTBUF_SUBST_EN
    localparam bit SUBST_EN = 1'b1;
`else
    localparam bit SUBST_EN = 1'b0;
`endif

    logic [DW-1:0] disp_mem [DEPTH];
    logic [IW-1:0] img_mem  [DEPTH];

    logic [PW-1:0] disp_wr_ptr;
    logic [PW-1:0] img_wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] disp_count;
    logic [CW-1:0] img_count;
    logic [CW-1:0] disp_count_next;
    logic [CW-1:0] img_count_next;

    logic pop;
    logic disp_full;
    logic img_full;
    logic disp_push;
    logic img_push;
    logic disp_drop;
    logic img_drop;

    logic [DW-1:0]  disp_head;
    logic [IW-1:0]  img_head;
    logic [DLW-1:0] head_disp;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of 2)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign out_valid = (disp_count != '0) && (img_count != '0);
    assign pop       = out_valid && out_ready;

    // A full FIFO still accepts a push when the same edge pops it.
    assign disp_full = (disp_count == FULL_CNT);
    assign img_full  = (img_count == FULL_CNT);
    assign disp_push = in_disp_valid && (!disp_full || pop);
    assign img_push  = in_img_valid  && (!img_full  || pop);
    assign disp_drop = in_disp_valid && disp_full && !pop;
    assign img_drop  = in_img_valid  && img_full  && !pop;

    // Next occupancy of each FIFO from its push and the shared pop
    always_comb begin
        disp_count_next = disp_count;
        img_count_next  = img_count;
        case ({disp_push, pop})
            2'b10:   disp_count_next = disp_count + 1'b1;
            2'b01:   disp_count_next = disp_count - 1'b1;
            default: disp_count_next = disp_count;
        endcase
        case ({img_push, pop})
            2'b10:   img_count_next = img_count + 1'b1;
            2'b01:   img_count_next = img_count - 1'b1;
            default: img_count_next = img_count;
        endcase
    end

    // Pointers, counts and the registered busy/overflow flags
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_wr_ptr <= '0;
            img_wr_ptr  <= '0;
            rd_ptr      <= '0;
            disp_count  <= '0;
            img_count   <= '0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (disp_push) disp_wr_ptr <= ptr_inc(disp_wr_ptr);
            if (img_push)  img_wr_ptr  <= ptr_inc(img_wr_ptr);
            if (pop)       rd_ptr      <= ptr_inc(rd_ptr);
            disp_count <= disp_count_next;
            img_count  <= img_count_next;
            busy       <= (disp_count_next >= AF_CNT) || (img_count_next >= AF_CNT);
            overflow   <= overflow || disp_drop || img_drop;
        end
    end

    // FIFO storage writes; contents need no reset since counts gate visibility
    always_ff @(posedge clk) begin
        if (disp_push) disp_mem[disp_wr_ptr] <= {in_disp_data, in_disp_masked, in_disp_filtered};
        if (img_push)  img_mem[img_wr_ptr]   <= {in_img_left, in_img_right};
    end

    assign disp_head    = disp_mem[rd_ptr];
    assign img_head     = img_mem[rd_ptr];
    assign head_disp    = disp_head[DW-1 -: DLW];
    assign out_masked   = disp_head[2*MULT_R-1 -: MULT_R];
    assign out_filtered = disp_head[MULT_R-1:0];
    assign out_left     = img_head[IW-1 -: ILW];
    assign out_right    = img_head[ILW-1:0];

    // Read-side lane substitution of masked/filtered disparities
    always_comb begin
        out_disp = head_disp;
        for (int unsigned i = 0; i < MULT_R; i++) begin
            if (SUBST_EN && (out_masked[i] || out_filtered[i])) begin
                out_disp[i*DISP_BITS +: DISP_BITS] = INVALID_V;
            end
        end
    end

endmodule

// File: tb/tb_dlsc_stereobm_outbuf.sv
// Directed bench for dlsc_stereobm_outbuf with a queue-based reference model.
module tb_dlsc_stereobm_outbuf;

    localparam int DB  = 6;
    localparam int MR  = 3;
    localparam int DT  = 9;
    localparam int DEP = 96;
    localparam int AF  = 88;
    localparam int INV = 63;

    typedef struct packed {
        logic [DB*MR-1:0] d;
        logic [MR-1:0]    m;
        logic [MR-1:0]    f;
    } dent_t;

    typedef struct packed {
        logic [DT*MR-1:0] l;
        logic [DT*MR-1:0] r;
    } ient_t;

    logic clk;
    logic rst;
    logic in_disp_valid;
    logic [DB*MR-1:0] in_disp_data;
    logic [MR-1:0] in_disp_masked;
    logic [MR-1:0] in_disp_filtered;
    logic in_img_valid;
    logic [DT*MR-1:0] in_img_left;
    logic [DT*MR-1:0] in_img_right;
    logic out_ready;
    logic out_valid;
    logic [DB*MR-1:0] out_disp;
    logic [MR-1:0] out_masked;
    logic [MR-1:0] out_filtered;
    logic [DT*MR-1:0] out_left;
    logic [DT*MR-1:0] out_right;
    logic busy;
    logic overflow;

    dlsc_stereobm_outbuf #(
        .DISP_BITS(DB), .MULT_R(MR), .DATA(DT), .DEPTH(DEP),
        .ALMOST_FULL(AF), .INVALID_DISP(INV)
    ) dut (
        .clk(clk), .rst(rst),
        .in_disp_valid(in_disp_valid), .in_disp_data(in_disp_data),
        .in_disp_masked(in_disp_masked), .in_disp_filtered(in_disp_filtered),
        .in_img_valid(in_img_valid), .in_img_left(in_img_left), .in_img_right(in_img_right),
        .out_ready(out_ready), .out_valid(out_valid), .out_disp(out_disp),
        .out_masked(out_masked), .out_filtered(out_filtered),
        .out_left(out_left), .out_right(out_right),
        .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dent_t dq[$];
    ient_t iq[$];
    bit m_busy;
    bit m_ovf;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DB*MR-1:0] exp_disp(input dent_t e);
        logic [DB*MR-1:0] v;
        v = e.d;
`ifdef DLSC_STEREOBM_OUTBUF_SUBST_EN
        for (int i = 0; i < MR; i++)
            if (e.m[i] || e.f[i]) v[i*DB +: DB] = DB'(INV);
`endif
        return v;
    endfunction

    // One clock: model the upcoming edge, let it happen, then compare status
    task automatic tick();
        bit pop;
        if (rst) begin
            dq.delete();
            iq.delete();
            m_busy = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            pop = (dq.size() != 0) && (iq.size() != 0) && out_ready;
            if (pop) begin
                check("out_disp", out_disp, exp_disp(dq[0]));
                check("out_masked", out_masked, dq[0].m);
                check("out_filtered", out_filtered, dq[0].f);
                check("out_left", out_left, iq[0].l);
                check("out_right", out_right, iq[0].r);
                void'(dq.pop_front());
                void'(iq.pop_front());
            end
            if (in_disp_valid) begin
                if (dq.size() < DEP) dq.push_back('{d: in_disp_data, m: in_disp_masked, f: in_disp_filtered});
                else m_ovf = 1'b1;
            end
            if (in_img_valid) begin
                if (iq.size() < DEP) iq.push_back('{l: in_img_left, r: in_img_right});
                else m_ovf = 1'b1;
            end
            m_busy = (dq.size() >= AF) || (iq.size() >= AF);
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, (dq.size() != 0) && (iq.size() != 0));
        check("busy", busy, m_busy);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic set_disp(input logic v, input logic [DB*MR-1:0] d, input logic [MR-1:0] m, input logic [MR-1:0] f);
        in_disp_valid = v; in_disp_data = d; in_disp_masked = m; in_disp_filtered = f;
    endtask

    task automatic set_img(input logic v, input logic [DT*MR-1:0] l, input logic [DT*MR-1:0] r);
        in_img_valid = v; in_img_left = l; in_img_right = r;
    endtask

    task automatic rand_disp();
        set_disp(1'b1, DB*MR'($urandom), MR'($urandom), MR'($urandom));
    endtask

    task automatic rand_img();
        set_img(1'b1, DT*MR'($urandom), DT*MR'($urandom));
    endtask

    task automatic idle();
        set_disp(1'b0, '0, '0, '0);
        set_img(1'b0, '0, '0);
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single pair, minimum latency
        out_ready = 1'b1;
        set_disp(1'b1, 18'h123, 3'b000, 3'b000);
        rand_img();
        tick();
        check("latency_valid", out_valid, 1'b1);
        idle();
        tick();
        tick();

        // image stream leads disparity by 40 cycles
        for (int i = 0; i < 10; i++) begin rand_img(); tick(); end
        idle();
        for (int i = 0; i < 40; i++) tick();
        check("skew_no_valid", out_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin rand_disp(); tick(); end
        idle();
        for (int i = 0; i < 12; i++) tick();

        // fill to full with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            rand_disp(); rand_img(); tick();
            if (i == AF - 2) check("busy_before_af", busy, 1'b0);
            if (i == AF - 1) check("busy_at_af", busy, 1'b1);
        end
        check("full_no_overflow", overflow, 1'b0);
        // push and pop at full: accepted
        out_ready = 1'b1;
        rand_disp(); rand_img(); tick();
        check("full_pushpop_ovf", overflow, 1'b0);
        // push at full without pop: dropped
        out_ready = 1'b0;
        rand_disp(); rand_img(); tick();
        check("overflow_set", overflow, 1'b1);
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < DEP + 4; i++) tick();
        check("drained_busy", busy, 1'b0);
        check("overflow_sticky", overflow, 1'b1);

        // reset with 20 beats buffered
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin rand_disp(); rand_img(); tick(); end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin rand_disp(); rand_img(); tick(); end
        idle();
        for (int i = 0; i < 5; i++) tick();

        // lane substitution
        out_ready = 1'b0;
        set_disp(1'b1, {6'd9, 6'd7, 6'd5}, 3'b010, 3'b000);
        rand_img();
        tick();
        idle();
`ifdef DLSC_STEREOBM_OUTBUF_SUBST_EN
        check("subst_lanes", out_disp, {6'd9, 6'd63, 6'd5});
`else
        check("subst_lanes", out_disp, {6'd9, 6'd7, 6'd5});
`endif
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            rand_disp(); rand_img();
            out_ready = 1'($urandom);
            tick();
        end
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dlsc_stereobm_outbuf.md
Name: dlsc_stereobm_outbuf

Overview:
Output buffering stage directly downstream of the stereo block-matching backend. It receives two independently timed streams: lane-parallel disparity results (MULT_R rows per beat) and the matching left/right image pixels. Each stream goes into its own FIFO. When both FIFO heads are present, the block pops them together and presents one aligned beat on a ready/valid output. It also drives an almost-full busy flag that throttles the upstream frontend.

Parameters:
DISP_BITS, 6, bits per disparity value
MULT_R, 3, rows processed in parallel (lanes)
DATA, 9, bits per image pixel
DEPTH, 96, entries per FIFO; covers worst-case pipeline skew
ALMOST_FULL, DEPTH-8, occupancy at or above which busy asserts
INVALID_DISP, 0, value substituted for masked/filtered lanes (see Optional Feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_disp_valid  in  1  disparity beat push strobe
in_disp_data  in  DISP_BITS*MULT_R  per-lane disparity, lane i at [i*DISP_BITS+:DISP_BITS]
in_disp_masked  in  MULT_R  per-lane masked flag
in_disp_filtered  in  MULT_R  per-lane filtered flag
in_img_valid  in  1  image beat push strobe
in_img_left  in  DATA*MULT_R  left pixels
in_img_right  in  DATA*MULT_R  right pixels
out_ready  in  1  consumer accepts beat
out_valid  out  1  aligned beat available
out_disp  out  DISP_BITS*MULT_R  disparity
out_masked  out  MULT_R  masked flags
out_filtered  out  MULT_R  filtered flags
out_left  out  DATA*MULT_R  left pixels
out_right  out  DATA*MULT_R  right pixels
busy  out  1  either FIFO occupancy >= ALMOST_FULL
overflow  out  1  sticky error: a push was attempted into a full FIFO

Behaviour:
- Reset: all pointers and counts = 0; out_valid=0; busy=0; overflow=0. Data outputs are don't-care while out_valid=0. Reset mid-operation discards all buffered beats in the cycle after rst is sampled.
- FIFOs: disp FIFO holds {disp,masked,filtered}; img FIFO holds {left,right}. Each has its own write pointer and occupancy count (0..DEPTH). Both share one read pointer because pops are always joint.
- Push: an in_*_valid sampled high at edge N writes the entry; the count increments at edge N.
- Pop: a pop occurs when out_valid && out_ready. It advances the read pointer and decrements both counts at the same edge.
- Simultaneous push and pop on one FIFO: the count is unchanged and both pointers advance.
- Output: first-word-fall-through. out_valid = (disp_count!=0) && (img_count!=0), driven from registered counts. Minimum latency is 1 cycle: with both entries pushed at edge N, out_valid is high in cycle N+1. The head entry is stable while out_valid && !out_ready.
- Full: a push into a FIFO with count==DEPTH is dropped and sets overflow=1. Overflow clears only on rst. A push while full that coincides with a pop is accepted, not an overflow.
- Empty: pop never occurs with either FIFO empty because out_valid=0. The non-empty FIFO retains its entries.
- busy is registered and updates on the edge where either count crosses ALMOST_FULL in either direction.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of 2; on reaching DEPTH-1 a pointer wraps to 0.
- Count widths are clog2(DEPTH+1).

Optional Feature:
Macro DLSC_STEREOBM_OUTBUF_SUBST_EN.
- Defined: each lane where out_masked[i] or out_filtered[i] is set outputs INVALID_DISP on out_disp. The substitution is applied at the FIFO read side and adds no latency.
- Undefined: out_disp is passed through unchanged. INVALID_DISP is unused.

Test Plan:
- Push 1 disp beat (data 0x123) and 1 img beat on the same cycle with out_ready=1 -> out_valid high exactly 1 cycle later with matching data, then low the following cycle.
- Push 10 img beats, then 10 disp beats 40 cycles later, with out_ready=1 -> out_valid stays 0 until the first disp beat lands; 10 beats emerge in push order, correctly paired.
- Hold out_ready=0 and push 88 beats on both streams (DEPTH=96) -> busy rises on the edge where count reaches 88; 8 more pushes fill the FIFOs with no overflow; a 97th push -> overflow=1 and the beat is dropped.
- At count=DEPTH, push and pop in the same cycle -> no overflow; count stays 96; the pushed entry emerges after 95 more pops.
- Assert rst for 1 cycle with 20 beats buffered -> out_valid=0, busy=0, overflow=0 next cycle; subsequent push pairs emerge normally.
- With SUBST_EN defined and INVALID_DISP=63, push lanes masked=3'b010, disparities {5,7,9} -> out_disp lanes {5,63,9}. With SUBST_EN undefined -> {5,7,9}.
